// File: rtl/unidade_de_emissao.sv
// unidade_de_emissao: in-order issue stage between the instruction queue and
// the reservation stations; renames destinations through a register status table.
`timescale 1ns/1ps
module unidade_de_emissao #(
    parameter int DATA_W   = 16,
    parameter int NUM_RS_R = 3,
    parameter int NUM_RS_I = 2
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Empty,
    input  logic [15:0]         Instr_In,
    output logic                Pop,
    output logic [2:0]          Rs1_Addr,
    output logic [2:0]          Rs2_Addr,
    input  logic [DATA_W-1:0]   Rs1_Data,
    input  logic [DATA_W-1:0]   Rs2_Data,
    input  logic [NUM_RS_R-1:0] RS_R_Free,
    input  logic [NUM_RS_I-1:0] RS_I_Free,
    input  logic                CDB_Valid,
    input  logic [2:0]          CDB_Tag,
    input  logic [DATA_W-1:0]   CDB_Data,
    output logic                Issue_Valid,
    output logic                Issue_Type,
    output logic [2:0]          Issue_Op,
    output logic [2:0]          Issue_Tag,
    output logic [DATA_W-1:0]   Issue_Vj,
    output logic [DATA_W-1:0]   Issue_Vk,
    output logic [2:0]          Issue_Qj,
    output logic [2:0]          Issue_Qk,
    output logic [15:0]         Issue_Imm,
    output logic                Busy
);

    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_SUB = 3'd3;
    localparam logic [2:0] OP_LD  = 3'd4;
    localparam logic [2:0] OP_ST  = 3'd5;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic [1:0]        state;
    logic [15:0]       instr_q;
    logic [7:0][2:0]   rst_q;

    logic [2:0]        op;
    logic [2:0]        fa;
    logic [2:0]        fb;
    logic [2:0]        fc;
    logic              is_r;
    logic              is_i;
    logic              op_ok;
    logic              writes_rd;
    logic              has_k;

    logic [2:0]        r_tag;
    logic [2:0]        i_tag;
    logic [2:0]        sel_tag;
    logic              stn_free;
    logic              in_hold;
    logic              issue_now;
    logic              drop;

    logic [2:0]        qj_raw;
    logic [2:0]        qk_raw;
    logic              hit_j;
    logic              hit_k;
    logic [2:0]        qj;
    logic [2:0]        qk;
    logic [DATA_W-1:0] vj;
    logic [DATA_W-1:0] vk;
    logic [15:0]       imm;

    assign op = instr_q[15:13];
    assign fa = instr_q[12:10];
    assign fb = instr_q[9:7];
    assign fc = instr_q[6:4];
    assign imm = {{9{instr_q[6]}}, instr_q[6:0]};

    assign is_r      = (op == OP_ADD) || (op == OP_SUB);
    assign is_i      = (op == OP_LD) || (op == OP_ST);
    assign op_ok     = is_r || is_i;
    assign writes_rd = is_r || (op == OP_LD);
    assign has_k     = is_r || (op == OP_ST);

    // ST carries its store data in field A, so port 2 follows the opcode
    assign Rs1_Addr = fb;
    assign Rs2_Addr = (op == OP_ST) ? fa : fc;

    always_comb begin
        r_tag = '0;
        for (int i = NUM_RS_R - 1; i >= 0; i--) begin
            if (RS_R_Free[i]) r_tag = 3'(i + 1);
        end
    end

    always_comb begin
        i_tag = '0;
        for (int i = NUM_RS_I - 1; i >= 0; i--) begin
            if (RS_I_Free[i]) i_tag = 3'(NUM_RS_R + i + 1);
        end
    end

    assign sel_tag   = is_r ? r_tag : i_tag;
    assign stn_free  = is_r ? (|RS_R_Free) : (is_i && (|RS_I_Free));
    assign in_hold   = (state == S_HOLD);
    assign issue_now = in_hold && op_ok && stn_free;
    assign drop      = in_hold && !op_ok;
    assign Busy      = in_hold && op_ok && !stn_free;

    // Operand lookup uses the pre-rename table, with a same-edge CDB bypass
    assign qj_raw = rst_q[fb];
    assign qk_raw = has_k ? rst_q[Rs2_Addr] : 3'd0;
    assign hit_j  = CDB_Valid && (qj_raw != 3'd0) && (CDB_Tag == qj_raw);
    assign hit_k  = CDB_Valid && (qk_raw != 3'd0) && (CDB_Tag == qk_raw);

    always_comb begin
        qj = hit_j ? 3'd0 : qj_raw;
        vj = '0;
        if (hit_j) begin
            vj = CDB_Data;
        end else if (qj_raw == 3'd0) begin
            vj = Rs1_Data;
        end
    end

    always_comb begin
        qk = hit_k ? 3'd0 : qk_raw;
        vk = '0;
        if (hit_k) begin
            vk = CDB_Data;
        end else if (has_k && (qk_raw == 3'd0)) begin
            vk = Rs2_Data;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state   <= S_IDLE;
            Pop     <= 1'b0;
            instr_q <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (!Empty) begin
                        Pop   <= 1'b1;
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    Pop     <= 1'b0;
                    instr_q <= Instr_In;
                    state   <= S_HOLD;
                end
                S_HOLD: begin
                    if (issue_now || drop) begin
                        if (!Empty) begin
                            Pop   <= 1'b1;
                            state <= S_WAIT;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    Pop   <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            Issue_Valid <= 1'b0;
            Issue_Type  <= 1'b0;
            Issue_Op    <= '0;
            Issue_Tag   <= '0;
            Issue_Vj    <= '0;
            Issue_Vk    <= '0;
            Issue_Qj    <= '0;
            Issue_Qk    <= '0;
            Issue_Imm   <= '0;
        end else begin
            Issue_Valid <= issue_now;
            Issue_Type  <= issue_now && is_i;
            Issue_Op    <= issue_now ? op : 3'd0;
            Issue_Tag   <= issue_now ? sel_tag : 3'd0;
            Issue_Vj    <= issue_now ? vj : '0;
            Issue_Vk    <= issue_now ? vk : '0;
            Issue_Qj    <= issue_now ? qj : 3'd0;
            Issue_Qk    <= issue_now ? qk : 3'd0;
            Issue_Imm   <= issue_now ? imm : 16'd0;
        end
    end

    // A rename on issue overrides a CDB clear of the same entry
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            rst_q <= '0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (CDB_Valid && (CDB_Tag != 3'd0) && (rst_q[i] == CDB_Tag)) begin
                    rst_q[i] <= 3'd0;
                end
            end
            if (issue_now && writes_rd) begin
                rst_q[fa] <= sel_tag;
            end
        end
    end

endmodule

// File: tb/tb_unidade_de_emissao.sv
// tb_unidade_de_emissao: directed scenarios followed by random traffic,
// checked against a queue/table reference of the issue rules.
`timescale 1ns/1ps
module tb_unidade_de_emissao;

    logic        Clock;
    logic        Reset;
    logic        Empty;
    logic [15:0] Instr_In;
    logic        Pop;
    logic [2:0]  Rs1_Addr;
    logic [2:0]  Rs2_Addr;
    logic [15:0] Rs1_Data;
    logic [15:0] Rs2_Data;
    logic [2:0]  RS_R_Free;
    logic [1:0]  RS_I_Free;
    logic        CDB_Valid;
    logic [2:0]  CDB_Tag;
    logic [15:0] CDB_Data;
    logic        Issue_Valid;
    logic        Issue_Type;
    logic [2:0]  Issue_Op;
    logic [2:0]  Issue_Tag;
    logic [15:0] Issue_Vj;
    logic [15:0] Issue_Vk;
    logic [2:0]  Issue_Qj;
    logic [2:0]  Issue_Qk;
    logic [15:0] Issue_Imm;
    logic        Busy;

    unidade_de_emissao #(.DATA_W(16), .NUM_RS_R(3), .NUM_RS_I(2)) dut (
        .Clock(Clock), .Reset(Reset), .Empty(Empty), .Instr_In(Instr_In),
        .Pop(Pop), .Rs1_Addr(Rs1_Addr), .Rs2_Addr(Rs2_Addr),
        .Rs1_Data(Rs1_Data), .Rs2_Data(Rs2_Data),
        .RS_R_Free(RS_R_Free), .RS_I_Free(RS_I_Free),
        .CDB_Valid(CDB_Valid), .CDB_Tag(CDB_Tag), .CDB_Data(CDB_Data),
        .Issue_Valid(Issue_Valid), .Issue_Type(Issue_Type), .Issue_Op(Issue_Op),
        .Issue_Tag(Issue_Tag), .Issue_Vj(Issue_Vj), .Issue_Vk(Issue_Vk),
        .Issue_Qj(Issue_Qj), .Issue_Qk(Issue_Qk), .Issue_Imm(Issue_Imm),
        .Busy(Busy)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // external register bank
    logic [15:0] rf [8];
    assign Rs1_Data = rf[Rs1_Addr];
    assign Rs2_Data = rf[Rs2_Addr];

    int          tests = 0;
    int          fails = 0;
    logic [15:0] q [$];
    logic [2:0]  mrst [8];
    logic        pending;
    logic [15:0] held;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit valid_op(input logic [15:0] ins);
        return ins[15:13] inside {3'd2, 3'd3, 3'd4, 3'd5};
    endfunction

    task automatic apply_q();
        Empty    = (q.size() == 0);
        Instr_In = Empty ? 16'h0 : q[0];
    endtask

    task automatic clear_model();
        for (int i = 0; i < 8; i++) mrst[i] = 3'd0;
        pending = 1'b0;
    endtask

    task automatic operand(input int src, input bit used, input logic cv,
                           input logic [2:0] ct, input logic [15:0] cd,
                           output logic [15:0] v, output logic [2:0] qq);
        v  = 16'h0;
        qq = 3'd0;
        if (used) begin
            qq = mrst[src];
            if (qq != 3'd0 && cv && ct == qq) begin
                v  = cd;
                qq = 3'd0;
            end else if (qq == 3'd0) begin
                v = rf[src];
            end
        end
    endtask

    task automatic tick();
        logic        pop_b;
        logic        cv;
        logic [2:0]  ct;
        logic [15:0] cd;
        logic [2:0]  rfr;
        logic [1:0]  ifr;
        logic [2:0]  op;
        logic [2:0]  etag;
        logic [15:0] evj;
        logic [15:0] evk;
        logic [2:0]  eqj;
        logic [2:0]  eqk;
        bit          isr;
        pop_b = Pop;
        cv = CDB_Valid; ct = CDB_Tag; cd = CDB_Data;
        rfr = RS_R_Free; ifr = RS_I_Free;
        @(posedge Clock);
        #1;
        op  = held[15:13];
        isr = (op == 3'd2) || (op == 3'd3);
        etag = 3'd0;
        if (Issue_Valid) begin
            check("issue_expected", 32'(pending), 32'd1);
            if (isr) begin
                for (int i = 0; i < 3; i++) if (rfr[i]) begin etag = 3'(i + 1); break; end
            end else begin
                for (int i = 0; i < 2; i++) if (ifr[i]) begin etag = 3'(i + 4); break; end
            end
            operand(int'(held[9:7]), 1'b1, cv, ct, cd, evj, eqj);
            operand(op == 3'd5 ? int'(held[12:10]) : int'(held[6:4]),
                    isr || op == 3'd5, cv, ct, cd, evk, eqk);
            check("m_type", 32'(Issue_Type), 32'(!isr));
            check("m_op", 32'(Issue_Op), 32'(op));
            check("m_tag", 32'(Issue_Tag), 32'(etag));
            check("m_vj", 32'(Issue_Vj), 32'(evj));
            check("m_qj", 32'(Issue_Qj), 32'(eqj));
            check("m_vk", 32'(Issue_Vk), 32'(evk));
            check("m_qk", 32'(Issue_Qk), 32'(eqk));
            check("m_imm", 32'(Issue_Imm), 32'({{9{held[6]}}, held[6:0]}));
        end else begin
            check("idle_zero", 32'(|{Issue_Type, Issue_Op, Issue_Tag, Issue_Vj,
                                     Issue_Vk, Issue_Qj, Issue_Qk, Issue_Imm}), 32'd0);
        end
        for (int i = 0; i < 8; i++) begin
            if (cv && ct != 3'd0 && mrst[i] == ct) mrst[i] = 3'd0;
        end
        if (Issue_Valid && pending) begin
            if (op != 3'd5) mrst[held[12:10]] = etag;
            pending = 1'b0;
        end
        if (pop_b) begin
            check("no_lost_instr", 32'(pending), 32'd0);
            held    = q.pop_front();
            pending = valid_op(held);
        end
        apply_q();
    endtask

    task automatic wait_busy(input string tag);
        int n = 0;
        #1;
        while (!Busy && n < 20) begin
            tick();
            #1;
            n++;
        end
        check(tag, 32'(Busy), 32'd1);
    endtask

    task automatic wait_issue(input string tag);
        int n = 0;
        tick();
        while (!Issue_Valid && n < 20) begin
            tick();
            n++;
        end
        check(tag, 32'(Issue_Valid), 32'd1);
    endtask

    task automatic chk_iss(input string tag, input logic typ, input logic [2:0] op,
                           input logic [2:0] stag, input logic [15:0] vj,
                           input logic [2:0] qj, input logic [15:0] vk, input logic [2:0] qk);
        check({tag, "_valid"}, 32'(Issue_Valid), 32'd1);
        check({tag, "_type"}, 32'(Issue_Type), 32'(typ));
        check({tag, "_op"}, 32'(Issue_Op), 32'(op));
        check({tag, "_tag"}, 32'(Issue_Tag), 32'(stag));
        check({tag, "_vj"}, 32'(Issue_Vj), 32'(vj));
        check({tag, "_qj"}, 32'(Issue_Qj), 32'(qj));
        check({tag, "_vk"}, 32'(Issue_Vk), 32'(vk));
        check({tag, "_qk"}, 32'(Issue_Qk), 32'(qk));
    endtask

    function automatic logic [15:0] rand_instr();
        logic [15:0] r;
        int k;
        r = 16'($urandom);
        k = $urandom_range(0, 11);
        if (k < 9) r[15:13] = 3'(2 + k % 4);
        else if (k == 9) r = 16'h0005;
        else if (k == 10) r[15:13] = 3'($urandom_range(0, 1));
        else r[15:13] = 3'($urandom_range(6, 7));
        return r;
    endfunction

    initial begin
        for (int i = 0; i < 8; i++) rf[i] = 16'(16'h1000 + i);
        rf[2] = 16'd7;
        rf[3] = 16'd9;
        Reset = 1'b0; Empty = 1'b1; Instr_In = 16'h0;
        RS_R_Free = 3'b000; RS_I_Free = 2'b00;
        CDB_Valid = 1'b0; CDB_Tag = 3'd0; CDB_Data = 16'h0;
        held = 16'h0;
        clear_model();
        repeat (2) @(posedge Clock);
        #1;
        check("reset_pop", 32'(Pop), 32'd0);
        check("reset_valid", 32'(Issue_Valid), 32'd0);
        check("reset_busy", 32'(Busy), 32'd0);
        Reset = 1'b1;

        // rename R2 and R3 so that a later reset has table entries to clear
        q.push_back(16'h4800);
        q.push_back(16'h4C00);
        RS_R_Free = 3'b111;
        apply_q();
        wait_issue("pre_issue0");
        wait_issue("pre_issue1");

        // reset while an ADD is stalled in HOLD
        RS_R_Free = 3'b000;
        q.push_back(16'h5C00);
        apply_q();
        wait_busy("t1_busy");
        Reset = 1'b0;
        #1;
        check("t1_pop", 32'(Pop), 32'd0);
        check("t1_busy_clr", 32'(Busy), 32'd0);
        check("t1_valid", 32'(Issue_Valid), 32'd0);
        check("t1_outs", 32'(|{Issue_Type, Issue_Op, Issue_Tag, Issue_Vj, Issue_Vk,
                               Issue_Qj, Issue_Qk, Issue_Imm}), 32'd0);
        clear_model();
        repeat (2) @(posedge Clock);
        #1;
        Reset = 1'b1;
        apply_q();
        repeat (4) begin
            tick();
            check("t1_no_pop", 32'(Pop), 32'd0);
        end

        // ADD R1,R2,R3 then SUB R4,R1,R1 twice
        q.push_back(16'h4530);
        q.push_back(16'h7090);
        q.push_back(16'h7090);
        apply_q();
        wait_busy("t2_busy");
        RS_R_Free = 3'b110;
        tick();
        chk_iss("t2", 1'b0, 3'd2, 3'd2, 16'd7, 3'd0, 16'd9, 3'd0);
        RS_R_Free = 3'b000;
        wait_busy("t3a_busy");
        RS_R_Free = 3'b100;
        tick();
        chk_iss("t3a", 1'b0, 3'd3, 3'd3, 16'd0, 3'd2, 16'd0, 3'd2);
        RS_R_Free = 3'b000;
        wait_busy("t3b_busy");
        RS_R_Free = 3'b001;
        CDB_Valid = 1'b1; CDB_Tag = 3'd2; CDB_Data = 16'd16;
        tick();
        chk_iss("t3b", 1'b0, 3'd3, 3'd1, 16'd16, 3'd0, 16'd16, 3'd0);
        CDB_Valid = 1'b0; RS_R_Free = 3'b000;

        // LD R5 stalled on full I stations, bubble, LD R6, ST R6, ADD R7,R6,R5
        q.push_back(16'h957F);
        q.push_back(16'h0005);
        q.push_back(16'h9803);
        q.push_back(16'hB901);
        q.push_back(16'h5F50);
        apply_q();
        wait_busy("t4_busy");
        repeat (3) begin
            tick();
            #1;
            check("t4_stall_busy", 32'(Busy), 32'd1);
            check("t4_stall_pop", 32'(Pop), 32'd0);
        end
        RS_I_Free = 2'b01;
        tick();
        chk_iss("t4", 1'b1, 3'd4, 3'd4, 16'd7, 3'd0, 16'd0, 3'd0);
        check("t4_imm", 32'(Issue_Imm), 32'h0000FFFF);
        RS_I_Free = 2'b00;
        check("t5_pop_bubble", 32'(Pop), 32'd1);
        tick();
        #1;
        check("t5_wait_valid", 32'(Issue_Valid), 32'd0);
        check("t5_wait_pop", 32'(Pop), 32'd0);
        tick();
        #1;
        check("t5_drop_valid", 32'(Issue_Valid), 32'd0);
        check("t5_drop_pop", 32'(Pop), 32'd1);
        wait_busy("t6_ld_busy");
        RS_I_Free = 2'b10;
        tick();
        chk_iss("t6_ld", 1'b1, 3'd4, 3'd5, 16'h1000, 3'd0, 16'd0, 3'd0);
        RS_I_Free = 2'b00;
        wait_busy("t6_st_busy");
        RS_I_Free = 2'b01;
        CDB_Valid = 1'b1; CDB_Tag = 3'd5; CDB_Data = 16'h1234;
        tick();
        chk_iss("t6_st", 1'b1, 3'd5, 3'd4, 16'd7, 3'd0, 16'h1234, 3'd0);
        check("t6_imm", 32'(Issue_Imm), 32'h00000001);
        CDB_Valid = 1'b0; RS_I_Free = 2'b00;
        wait_busy("t6_add_busy");
        RS_R_Free = 3'b111;
        tick();
        chk_iss("t6_add", 1'b0, 3'd2, 3'd1, 16'h1006, 3'd0, 16'd0, 3'd4);

        // random traffic against the reference model
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if (cyc < 1300 && q.size() < 3 && $urandom_range(0, 2) != 0)
                q.push_back(rand_instr());
            RS_R_Free = ($urandom_range(0, 3) == 0) ? 3'b000 : 3'($urandom_range(0, 7));
            RS_I_Free = 2'($urandom_range(0, 3));
            CDB_Valid = 1'($urandom_range(0, 1));
            CDB_Tag   = 3'($urandom_range(0, 5));
            CDB_Data  = 16'($urandom);
            apply_q();
            tick();
        end
        RS_R_Free = 3'b111; RS_I_Free = 2'b11; CDB_Valid = 1'b0;
        for (int n = 0; n < 60 && (q.size() != 0 || pending); n++) tick();
        check("drain_done", 32'(q.size() == 0 && !pending), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
